display_scan: RTL and testbench



---
 rtl/display_pkg.sv | 34 +++
 rtl/bcd_to_seg.sv | 30 +++
 rtl/display_scan.sv | 161 ++++++++++++++++
 tb/tb_display_scan.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg
// Shared definitions for the seven-segment display blocks: the scan state
// encoding, the active-low glyph constants ({g,f,e,d,c,b,a}, 0 = segment lit),
// the separator-dot position mask and a small anode-select helper.
package display_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit positions followed by a separator dot: after seconds, minutes, hours.
  localparam logic [7:0] SEP_MASK = 8'b0101_0100;

  // Active-low one-cold anode pattern for digit position idx.
  function automatic logic [7:0] anode_for(input logic [2:0] idx);
    return ~(8'b1 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg
// Purely combinational BCD to seven-segment decoder, active-low outputs.
// Values 10..15 are not BCD and are shown as a dash (segment g only).
// Ports:
//   bcd  in  4  digit value
//   seg  out 7  {g,f,e,d,c,b,a}, active-low
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// display_scan
// Multiplexed 8-digit common-anode seven-segment driver for the stopwatch
// time digits HH:MM:SS.CC. All eight digits are latched into a shadow array
// once per frame, then each digit is driven for DWELL cycles followed by GAP
// all-off cycles. Applies leading-zero blanking, separator dots and a dash
// glyph for invalid digits. All outputs are registered.
// Ports:
//   clk_milisec  in  1  scan clock
//   rst          in  1  asynchronous reset, active-high
//   en           in  1  display enable; 0 blanks and parks the scanner
//   i_hr_1..i_cent_0 in 4 each  BCD time digits (*_1 = tens)
//   an           out 8  digit anodes, active-low; an[0] = cent_0, an[7] = hr_1
//   seg          out 7  {g,f,e,d,c,b,a}, active-low
//   dp           out 1  decimal point, active-low
module display_scan
  import display_pkg::*;
#(
  parameter int DWELL    = 4,
  parameter int GAP      = 1,
  parameter int BLANK_LZ = 1
) (
  input  logic       clk_milisec,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] i_hr_1,
  input  logic [3:0] i_hr_0,
  input  logic [3:0] i_min_1,
  input  logic [3:0] i_min_0,
  input  logic [3:0] i_sec_1,
  input  logic [3:0] i_sec_0,
  input  logic [3:0] i_cent_1,
  input  logic [3:0] i_cent_0,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int MAX_CNT = (DWELL > GAP) ? DWELL : GAP;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  scan_state_t state, state_next;
  logic [2:0]       idx, idx_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0][3:0]  shadow, shadow_next, digits_in;
  logic             load;
  logic [3:0]       digit_sel;
  logic [6:0]       glyph;
  logic [7:0]       blank;
  logic             lz_run;
  logic [7:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_d;

  assign digits_in = {i_hr_1, i_hr_0, i_min_1, i_min_0,
                      i_sec_1, i_sec_0, i_cent_1, i_cent_0};

  // Outputs are registered from next-cycle values, so the shadow contents
  // the next cycle will display are needed here, including a fresh snapshot.
  assign shadow_next = load ? digits_in : shadow;
  assign digit_sel   = shadow_next[idx_next];

  bcd_to_seg u_dec (
    .bcd (digit_sel),
    .seg (glyph)
  );

  always_ff @(posedge clk_milisec or posedge rst) begin
    if (rst) begin
      state  <= ST_LOAD;
      idx    <= '0;
      cnt    <= '0;
      shadow <= '0;
      an     <= 8'hFF;
      seg    <= SEG_BLANK;
      dp     <= 1'b1;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      cnt    <= cnt_next;
      shadow <= shadow_next;
      an     <= an_d;
      seg    <= seg_d;
      dp     <= dp_d;
    end
  end

  // The counter restarts whenever the FSM moves to a new state or a new
  // digit (DRIVE to DRIVE when GAP is zero).
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt + CNT_W'(1);
    load       = 1'b0;
    if (!en) begin
      state_next = ST_LOAD;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_LOAD: begin
          load       = 1'b1;
          state_next = ST_DRIVE;
          idx_next   = '0;
          cnt_next   = '0;
        end
        ST_DRIVE: begin
          if (cnt == DWELL_LAST) begin
            cnt_next = '0;
            if (GAP != 0) begin
              state_next = ST_GAP;
            end else if (idx == 3'd7) begin
              state_next = ST_LOAD;
              idx_next   = '0;
            end else begin
              idx_next = idx + 3'd1;
            end
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt_next = '0;
            if (idx == 3'd7) begin
              state_next = ST_LOAD;
              idx_next   = '0;
            end else begin
              state_next = ST_DRIVE;
              idx_next   = idx + 3'd1;
            end
          end
        end
        default: begin
          state_next = ST_LOAD;
          idx_next   = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Leading-zero run scans from the hours-tens digit downwards; an invalid
  // digit is nonzero and therefore ends the run. Only positions 7..3 blank.
  always_comb begin
    lz_run = 1'b1;
    blank  = '0;
    an_d   = 8'hFF;
    seg_d  = SEG_BLANK;
    dp_d   = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      lz_run   = lz_run && (shadow_next[k] == 4'd0);
      blank[k] = (BLANK_LZ != 0) && (k >= 3) && lz_run;
    end
    if (state_next == ST_DRIVE) begin
      an_d  = anode_for(idx_next);
      seg_d = blank[idx_next] ? SEG_BLANK : glyph;
      dp_d  = ~SEP_MASK[idx_next];
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan
// Self-checking bench for display_scan. Two instances share the stimulus:
// dut_a with default timing and blanking, dut_b with DWELL=2, GAP=0 and
// blanking disabled. A frame-position reference model predicts every output
// cycle; a table of fixed digit patterns and a few hand-written sequences
// cover the specific display cases and mid-frame events.
module tb_display_scan;

  localparam int DWELL_A = 4;
  localparam int GAP_A   = 1;
  localparam int DWELL_B = 2;
  localparam int GAP_B   = 0;
  localparam int FRAME_A = 1 + 8 * (DWELL_A + GAP_A);
  localparam int FRAME_B = 1 + 8 * (DWELL_B + GAP_B);

  logic clk_milisec = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic [7:0][3:0] dig = '0;
  logic [7:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic dp_a, dp_b;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  bit check_on = 1'b0;

  typedef struct {
    string           name;
    logic [31:0]     digits;
    bit              use_b;
    logic [7:0][6:0] exp_seg;
    logic [7:0]      exp_dp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk_milisec = ~clk_milisec;

  always @(posedge clk_milisec) cyc++;

  display_scan #(.DWELL(DWELL_A), .GAP(GAP_A), .BLANK_LZ(1)) dut_a (
    .clk_milisec (clk_milisec), .rst (rst), .en (en),
    .i_hr_1 (dig[7]), .i_hr_0 (dig[6]), .i_min_1 (dig[5]), .i_min_0 (dig[4]),
    .i_sec_1 (dig[3]), .i_sec_0 (dig[2]), .i_cent_1 (dig[1]), .i_cent_0 (dig[0]),
    .an (an_a), .seg (seg_a), .dp (dp_a)
  );

  display_scan #(.DWELL(DWELL_B), .GAP(GAP_B), .BLANK_LZ(0)) dut_b (
    .clk_milisec (clk_milisec), .rst (rst), .en (en),
    .i_hr_1 (dig[7]), .i_hr_0 (dig[6]), .i_min_1 (dig[5]), .i_min_0 (dig[4]),
    .i_sec_1 (dig[3]), .i_sec_0 (dig[2]), .i_cent_1 (dig[1]), .i_cent_0 (dig[0]),
    .an (an_b), .seg (seg_b), .dp (dp_b)
  );

  function automatic logic [6:0] ref_glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Expected {an, seg, dp} from the position inside the frame: position 0 is
  // the all-off load cycle, then eight slots of dwell-on plus gap-off cycles.
  function automatic logic [15:0] model_out(input int pos, input logic [7:0][3:0] snap,
                                            input int dwell, input int gap, input bit blz);
    int q, d, ph;
    bit allz;
    logic [7:0] an_e;
    logic [6:0] seg_e;
    logic dp_e;
    an_e  = 8'hFF;
    seg_e = 7'h7F;
    dp_e  = 1'b1;
    if (pos > 0) begin
      q  = pos - 1;
      d  = q / (dwell + gap);
      ph = q % (dwell + gap);
      if (ph < dwell) begin
        an_e[d] = 1'b0;
        allz = 1'b1;
        for (int j = d; j < 8; j++) if (snap[j] != 4'd0) allz = 1'b0;
        seg_e = (blz && d >= 3 && allz) ? 7'h7F : ref_glyph(snap[d]);
        dp_e  = (d == 2 || d == 4 || d == 6) ? 1'b0 : 1'b1;
      end
    end
    return {an_e, seg_e, dp_e};
  endfunction

  int pos_a = 0;
  int pos_b = 0;
  logic [7:0][3:0] snap_a = '0;
  logic [7:0][3:0] snap_b = '0;

  // Reference model: advances the frame position each enabled edge and takes
  // the snapshot on the edge that leaves the load cycle.
  always @(posedge clk_milisec or posedge rst) begin
    if (rst) begin
      pos_a = 0; pos_b = 0; snap_a = '0; snap_b = '0;
    end else if (!en) begin
      pos_a = 0; pos_b = 0;
    end else begin
      pos_a = (pos_a + 1) % FRAME_A;
      pos_b = (pos_b + 1) % FRAME_B;
      if (pos_a == 1) snap_a = dig;
      if (pos_b == 1) snap_b = dig;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk_milisec) begin
    if (check_on) begin
      checkOutput("scan_a", {16'h0, an_a, seg_a, dp_a},
                  {16'h0, model_out(pos_a, snap_a, DWELL_A, GAP_A, 1'b1)});
      checkOutput("scan_b", {16'h0, an_b, seg_b, dp_b},
                  {16'h0, model_out(pos_b, snap_b, DWELL_B, GAP_B, 1'b0)});
    end
  end

  task automatic tick();
    @(posedge clk_milisec);
    #2;
  endtask

  task automatic waitAn(input logic [7:0] target, input int budget, input string name);
    bit found = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_milisec);
      if (an_a === target) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      vec_cnt++;
      err_cnt++;
      $display("[TB] FAIL %s: an never reached %h within %0d cycles, last %h", name, target, budget, an_a);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] digits);
    tick();
    dig = digits;
    en  = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic addVec(input string n, input logic [31:0] d, input bit b,
                        input logic [55:0] s);
    vec_t v;
    v.name    = n;
    v.digits  = d;
    v.use_b   = b;
    v.exp_seg = s;
    v.exp_dp  = 8'hAB;
    tbl.push_back(v);
  endtask

  task automatic runVec(input vec_t v);
    logic [7:0][6:0] segs = '0;
    logic [7:0] dps = '0;
    logic [7:0] seen = '0;
    logic [7:0] anv;
    applyStimulus(v.digits);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_milisec);
      anv = v.use_b ? an_b : an_a;
      for (int k = 0; k < 8; k++) begin
        if (anv == ~(8'b1 << k)) begin
          seen[k] = 1'b1;
          segs[k] = v.use_b ? seg_b : seg_a;
          dps[k]  = v.use_b ? dp_b : dp_a;
        end
      end
    end
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("%s idx%0d", v.name, k), {23'h0, seen[k], segs[k], dps[k]},
                  {23'h0, 1'b1, v.exp_seg[k], v.exp_dp[k]});
  endtask

  function automatic logic [3:0] randDigit();
    int r = $urandom_range(0, 9);
    if (r < 5) return 4'd0;
    if (r < 8) return 4'($urandom_range(1, 9));
    return 4'($urandom_range(10, 15));
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t1, t2;
    addVec("t_01_23_45_67", 32'h0123_4567, 1'b0, {7'h7F,7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78});
    addVec("t_00_00_05_30", 32'h0000_0530, 1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h12,7'h30,7'h40});
    addVec("t_05_30_nolz",  32'h0000_0530, 1'b1, {7'h40,7'h40,7'h40,7'h40,7'h40,7'h12,7'h30,7'h40});
    addVec("t_cent0_bad",   32'h0000_000C, 1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40,7'h40,7'h3F});
    addVec("t_hr1_bad",     32'hA000_0000, 1'b0, {7'h3F,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40});
    addVec("t_mid_bad",     32'h00B0_0006, 1'b0, {7'h7F,7'h7F,7'h3F,7'h40,7'h40,7'h40,7'h40,7'h02});
    addVec("t_23_59_59_99", 32'h2359_5999, 1'b0, {7'h24,7'h30,7'h12,7'h10,7'h12,7'h10,7'h10,7'h10});
    addVec("t_partial_lz",  32'h0018_0000, 1'b0, {7'h7F,7'h7F,7'h79,7'h00,7'h40,7'h40,7'h40,7'h40});

    repeat (3) @(posedge clk_milisec);
    check_on = 1'b1;

    foreach (tbl[i]) runVec(tbl[i]);

    // Reset hold with en high, then first drive right after release.
    tick();
    rst = 1'b1;
    #1 checkOutput("reset_hold", {16'h0, an_a, seg_a, dp_a}, {16'h0, 8'hFF, 7'h7F, 1'b1});
    tick();
    tick();
    checkOutput("reset_held", {16'h0, an_a, seg_a, dp_a}, {16'h0, 8'hFF, 7'h7F, 1'b1});
    rst = 1'b0;
    @(posedge clk_milisec);
    #1 checkOutput("first_drive", {24'h0, an_a}, {24'h0, 8'hFE});

    // Mid-frame input change: current frame keeps old values.
    applyStimulus(32'h0100_0003);
    waitAn(8'hDF, 60, "wait_idx5");
    tick();
    dig[0] = 4'd4;
    dig[6] = 4'd2;
    waitAn(8'hBF, 30, "wait_idx6_old");
    checkOutput("old_hr0_idx6", {25'h0, seg_a}, {25'h0, 7'h79});
    waitAn(8'hFE, 30, "wait_idx0_new");
    t1 = cyc;
    checkOutput("new_cent0_idx0", {25'h0, seg_a}, {25'h0, 7'h19});
    waitAn(8'hBF, 60, "wait_idx6_new");
    checkOutput("new_hr0_idx6", {25'h0, seg_a}, {25'h0, 7'h24});
    waitAn(8'hFE, 60, "wait_next_frame");
    t2 = cyc;
    checkOutput("frame_period", t2 - t1, 32'd41);

    // en low at idx 3, hold, then resume.
    waitAn(8'hF7, 60, "wait_idx3");
    tick();
    en = 1'b0;
    @(posedge clk_milisec);
    #1 checkOutput("en_off", {16'h0, an_a, seg_a, dp_a}, {16'h0, 8'hFF, 7'h7F, 1'b1});
    repeat (5) tick();
    checkOutput("en_hold", {16'h0, an_a, seg_a, dp_a}, {16'h0, 8'hFF, 7'h7F, 1'b1});
    en = 1'b1;
    @(negedge clk_milisec);
    checkOutput("en_load_cycle", {24'h0, an_a}, {24'h0, 8'hFF});
    @(negedge clk_milisec);
    checkOutput("en_resume", {24'h0, an_a}, {24'h0, 8'hFE});

    // rst pulse during DRIVE clears outputs without waiting for a clock edge.
    waitAn(8'hEF, 60, "wait_idx4");
    tick();
    rst = 1'b1;
    #1 checkOutput("rst_async", {16'h0, an_a, seg_a, dp_a}, {16'h0, 8'hFF, 7'h7F, 1'b1});
    tick();
    rst = 1'b0;
    @(posedge clk_milisec);
    #1 checkOutput("rst_restart", {24'h0, an_a}, {24'h0, 8'hFE});

    // Random digits, enable drops and reset pulses against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 7) == 0) dig[$urandom_range(0, 7)] = randDigit();
      if ($urandom_range(0, 99) == 0) dig = '0;
      if (en) begin
        if ($urandom_range(0, 59) == 0) en = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        en = 1'b1;
      end
      rst = ($urandom_range(0, 399) == 0);
    end
    tick();
    rst = 1'b0;
    en  = 1'b1;
    repeat (50) tick();

    check_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
